// File: rtl/hermes_port_sink.sv
// Termination sink for an open Hermes router port: returns credit with a
// periodic stall pattern, parses header/size/payload and keeps running stats.
module hermes_port_sink #(
   parameter int          FLIT_SIZE    = 32,
   parameter int          STALL_PERIOD = 0,
   parameter int          STALL_LEN    = 0,
   parameter logic [31:0] MAX_SIZE     = 32'd4096
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 rx_i,
   input  logic [FLIT_SIZE-1:0] data_i,
   output logic                 credit_o,
   output logic                 msg_done_o,
   output logic [15:0]          last_target_o,
   output logic [31:0]          last_size_o,
   output logic [31:0]          last_service_o,
   output logic [31:0]          last_latency_o,
   output logic [31:0]          msg_cnt_o,
   output logic [63:0]          flit_cnt_o,
   output logic                 busy_o,
   output logic                 err_o
);
   // state   | meaning
   // HDR     | idle, next accepted flit is a header
   // SIZE    | header taken, next accepted flit is the payload size
   // PAYLOAD | consuming payload flits until remaining reaches zero

   localparam int          PERIOD     = (STALL_PERIOD > 0) ? STALL_PERIOD : 1;
   localparam bit          STALL_EN   = (STALL_PERIOD > 0) && (STALL_LEN > 0);
   localparam logic [31:0] STALL_THR  = 32'(PERIOD - STALL_LEN);
   localparam logic [31:0] STALL_LAST = 32'(PERIOD - 1);

   typedef enum logic [1:0] {HDR, SIZE, PAYLOAD} state_t;

   state_t      state;
   logic [31:0] stall_cnt;
   logic [31:0] size_q;
   logic [31:0] remaining;
   logic [31:0] service_q;
   logic [31:0] lat_cnt;
   logic [15:0] target_q;
   logic [31:0] data32;
   logic [31:0] svc_now;
   logic        acc;
   logic        done_now;

   assign acc    = rx_i && credit_o;
   assign data32 = 32'(data_i);
   assign busy_o = (state != HDR);

   always_comb begin
      svc_now  = (remaining == size_q) ? data32 : service_q;
      done_now = 1'b0;
      if (acc && (state == SIZE) && (data32 == 32'd0)) begin
         done_now = 1'b1;
      end
      if (acc && (state == PAYLOAD) && (remaining == 32'd1)) begin
         done_now = 1'b1;
      end
   end

   // Credit pattern free-runs from reset release, independent of traffic.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt <= '0;
         credit_o  <= 1'b0;
      end else begin
         stall_cnt <= (stall_cnt == STALL_LAST) ? 32'd0 : stall_cnt + 32'd1;
         credit_o  <= !STALL_EN || (stall_cnt < STALL_THR);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state          <= HDR;
         size_q         <= '0;
         remaining      <= '0;
         service_q      <= '0;
         lat_cnt        <= '0;
         target_q       <= '0;
         msg_done_o     <= 1'b0;
         last_target_o  <= '0;
         last_size_o    <= '0;
         last_service_o <= '0;
         last_latency_o <= '0;
         msg_cnt_o      <= '0;
         flit_cnt_o     <= '0;
         err_o          <= 1'b0;
      end else begin
         msg_done_o <= 1'b0;
         // lat_cnt holds the cycle distance from the header acceptance.
         if (busy_o && (lat_cnt != 32'hFFFF_FFFF)) begin
            lat_cnt <= lat_cnt + 32'd1;
         end
         if (acc) begin
            flit_cnt_o <= flit_cnt_o + 64'd1;
            case (state)
               HDR: begin
                  target_q <= data32[15:0];
                  lat_cnt  <= 32'd1;
                  state    <= SIZE;
               end
               SIZE: begin
                  size_q    <= data32;
                  remaining <= data32;
                  if (data32 > MAX_SIZE) begin
                     err_o <= 1'b1;
                  end
                  state <= (data32 == 32'd0) ? HDR : PAYLOAD;
               end
               PAYLOAD: begin
                  if (remaining == size_q) begin
                     service_q <= data32;
                  end
                  remaining <= remaining - 32'd1;
                  if (remaining == 32'd1) begin
                     state <= HDR;
                  end
               end
               default: state <= HDR;
            endcase
         end
         if (done_now) begin
            msg_done_o     <= 1'b1;
            last_target_o  <= target_q;
            last_size_o    <= (state == SIZE) ? 32'd0 : size_q;
            last_service_o <= (state == SIZE) ? 32'd0 : svc_now;
            last_latency_o <= lat_cnt;
            msg_cnt_o      <= msg_cnt_o + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_hermes_port_sink.sv
// Bench for hermes_port_sink: two instances (free credit and 4/2 stall pattern)
// fed identical packet streams, checked each cycle against a packet-level model.
module tb_hermes_port_sink;
   localparam int P1 = 4;
   localparam int L1 = 2;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        rx [2];
   logic [31:0] data [2];
   logic        credit [2];
   logic        done [2];
   logic [15:0] tgt [2];
   logic [31:0] lsize [2];
   logic [31:0] lsvc [2];
   logic [31:0] llat [2];
   logic [31:0] mcnt [2];
   logic [63:0] fcnt [2];
   logic        busy [2];
   logic        err [2];

   always #5 clk = ~clk;

   hermes_port_sink #(.FLIT_SIZE(32), .STALL_PERIOD(0), .STALL_LEN(0), .MAX_SIZE(32'd4096)) dut0 (
      .clk_i(clk), .rst_ni(rst_ni), .rx_i(rx[0]), .data_i(data[0]), .credit_o(credit[0]),
      .msg_done_o(done[0]), .last_target_o(tgt[0]), .last_size_o(lsize[0]),
      .last_service_o(lsvc[0]), .last_latency_o(llat[0]), .msg_cnt_o(mcnt[0]),
      .flit_cnt_o(fcnt[0]), .busy_o(busy[0]), .err_o(err[0]));

   hermes_port_sink #(.FLIT_SIZE(32), .STALL_PERIOD(P1), .STALL_LEN(L1), .MAX_SIZE(32'd4096)) dut1 (
      .clk_i(clk), .rst_ni(rst_ni), .rx_i(rx[1]), .data_i(data[1]), .credit_o(credit[1]),
      .msg_done_o(done[1]), .last_target_o(tgt[1]), .last_size_o(lsize[1]),
      .last_service_o(lsvc[1]), .last_latency_o(llat[1]), .msg_cnt_o(mcnt[1]),
      .flit_cnt_o(fcnt[1]), .busy_o(busy[1]), .err_o(err[1]));

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   int unsigned gap_pct = 0;
   int unsigned tb_cyc = 0;
   int unsigned pulses0 = 0;
   int unsigned last_done_cyc = 0;
   int unsigned done_gap = 0;
   logic [31:0] q0 [$];
   logic [31:0] q1 [$];

   task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s[%0d]: got %0h expected %0h", nm, id, act, exp);
      else n_pass++;
   endtask

   function automatic bit credit_fn(input int id, input int unsigned n);
      int p;
      int l;
      p = (id == 0) ? 0 : P1;
      l = (id == 0) ? 0 : L1;
      if (n == 0) return 1'b0;
      if (p == 0 || l == 0) return 1'b1;
      return ((n - 1) % p) < (p - l);
   endfunction

   // Packet-level model: counts flits of the current packet, no state encoding.
   int unsigned mcyc;
   longint      pcnt [2];
   logic [15:0] cur_tgt [2];
   logic [31:0] cur_size [2];
   logic [31:0] cur_svc [2];
   int unsigned hcyc [2];
   logic        e_done [2];
   logic [15:0] e_tgt [2];
   logic [31:0] e_size [2];
   logic [31:0] e_svc [2];
   logic [31:0] e_lat [2];
   logic [31:0] e_cnt [2];
   logic [63:0] e_flit [2];
   logic        e_busy [2];
   logic        e_err [2];
   logic        e_cred [2];

   task automatic complete(input int i);
      e_done[i] = 1'b1;
      e_tgt[i]  = cur_tgt[i];
      e_size[i] = cur_size[i];
      e_svc[i]  = (cur_size[i] == 0) ? 32'd0 : cur_svc[i];
      e_lat[i]  = mcyc - hcyc[i];
      e_cnt[i]  = e_cnt[i] + 32'd1;
      pcnt[i]   = 0;
   endtask

   initial begin
      bit a;
      forever begin
         @(posedge clk or negedge rst_ni);
         if (!rst_ni) begin
            mcyc = 0;
            for (int i = 0; i < 2; i++) begin
               pcnt[i] = 0; e_done[i] = 0; e_tgt[i] = 0; e_size[i] = 0; e_svc[i] = 0;
               e_lat[i] = 0; e_cnt[i] = 0; e_flit[i] = 0; e_busy[i] = 0; e_err[i] = 0;
               e_cred[i] = 0;
            end
         end else begin
            for (int i = 0; i < 2; i++) begin
               a = rx[i] && credit_fn(i, mcyc);
               e_done[i] = 1'b0;
               if (a) begin
                  e_flit[i] = e_flit[i] + 64'd1;
                  if (pcnt[i] == 0) begin
                     cur_tgt[i] = data[i][15:0];
                     hcyc[i] = mcyc;
                     pcnt[i] = 1;
                  end else if (pcnt[i] == 1) begin
                     cur_size[i] = data[i];
                     if (data[i] > 32'd4096) e_err[i] = 1'b1;
                     if (data[i] == 0) complete(i);
                     else pcnt[i] = 2;
                  end else begin
                     if (pcnt[i] == 2) cur_svc[i] = data[i];
                     if (pcnt[i] == longint'(cur_size[i]) + 1) complete(i);
                     else pcnt[i]++;
                  end
               end
               e_busy[i] = (pcnt[i] != 0);
            end
            mcyc++;
            for (int i = 0; i < 2; i++) e_cred[i] = credit_fn(i, mcyc);
         end
      end
   end

   initial forever begin
      @(posedge clk);
      tb_cyc++;
   end

   // Senders: present the queue head, pop only when the flit will be taken.
   initial begin
      rx[0] = 0; rx[1] = 0; data[0] = 0; data[1] = 0;
      forever begin
         @(negedge clk);
         rx[0] = 0; data[0] = $urandom;
         if (q0.size() > 0 && $urandom_range(99) >= gap_pct) begin
            rx[0] = 1; data[0] = q0[0];
            if (credit[0]) void'(q0.pop_front());
         end
         rx[1] = 0; data[1] = $urandom;
         if (q1.size() > 0 && $urandom_range(99) >= gap_pct) begin
            rx[1] = 1; data[1] = q1[0];
            if (credit[1]) void'(q1.pop_front());
         end
      end
   end

   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("credit", i, credit[i], e_cred[i]);
         chk("msg_done", i, done[i], e_done[i]);
         chk("last_target", i, tgt[i], e_tgt[i]);
         chk("last_size", i, lsize[i], e_size[i]);
         chk("last_service", i, lsvc[i], e_svc[i]);
         chk("last_latency", i, llat[i], e_lat[i]);
         chk("msg_cnt", i, mcnt[i], e_cnt[i]);
         chk("flit_cnt", i, fcnt[i], e_flit[i]);
         chk("busy", i, busy[i], e_busy[i]);
         chk("err", i, err[i], e_err[i]);
      end
      if (done[0] === 1'b1) begin
         pulses0++;
         done_gap = tb_cyc - last_done_cyc;
         last_done_cyc = tb_cyc;
      end
   end

   task automatic push(input logic [31:0] w);
      q0.push_back(w);
      q1.push_back(w);
   endtask

   task automatic push_pkt(input logic [15:0] t, input int unsigned n);
      push({$urandom_range(16'hFFFF, 0) & 32'hFFFF, 16'h0} | {16'h0, t});
      push(n);
      for (int k = 0; k < n; k++) push($urandom);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((q0.size() != 0 || q1.size() != 0) && k < 40000) begin
         @(negedge clk);
         k++;
      end
      chk("drain_timeout", 0, 64'(q0.size() + q1.size()), 64'd0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst_ni = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_credit", i, credit[i], 1'b0);
         chk("rst_flit_cnt", i, fcnt[i], 64'd0);
         chk("rst_busy", i, busy[i], 1'b0);
      end

      // Single packet, continuous rx.
      push(32'hABCD_0102); push(32'd3); push(32'h10); push(32'hA); push(32'hB);
      rst_ni = 1'b1;
      wait_idle();
      chk("t1_pulses", 0, 64'(pulses0), 64'd1);
      chk("t1_target", 0, tgt[0], 16'h0102);
      chk("t1_size", 0, lsize[0], 32'd3);
      chk("t1_service", 0, lsvc[0], 32'h10);
      chk("t1_latency", 0, llat[0], 32'd4);
      chk("t1_msg_cnt", 0, mcnt[0], 32'd1);
      chk("t1_flit_cnt", 0, fcnt[0], 64'd5);
      chk("t1_latency", 1, llat[1], 32'd8);
      chk("t1_service", 1, lsvc[1], 32'h10);

      // Zero-size packet.
      push(32'h0000_BEEF); push(32'd0);
      wait_idle();
      chk("t3_size", 0, lsize[0], 32'd0);
      chk("t3_service", 0, lsvc[0], 32'd0);
      chk("t3_flit_cnt", 0, fcnt[0], 64'd7);
      chk("t3_busy", 0, busy[0], 1'b0);
      chk("t3_latency", 0, llat[0], 32'd1);

      // Two back-to-back 2-payload packets.
      push_pkt(16'h0201, 2);
      push_pkt(16'h0202, 2);
      wait_idle();
      chk("t5_done_gap", 0, 64'(done_gap), 64'd4);
      chk("t5_msg_cnt", 0, mcnt[0], 32'd4);
      chk("t5_flit_cnt", 0, fcnt[0], 64'd15);
      chk("t5_target", 0, tgt[0], 16'h0202);

      // Oversize packet, fully consumed, then a legal packet.
      chk("t4_err_before", 0, err[0], 1'b0);
      push_pkt(16'h0300, 5000);
      push_pkt(16'h0301, 1);
      wait_idle();
      for (int i = 0; i < 2; i++) begin
         chk("t4_err", i, err[i], 1'b1);
         chk("t4_msg_cnt", i, mcnt[i], 32'd6);
         chk("t4_flit_cnt", i, fcnt[i], 64'd5020);
         chk("t4_size", i, lsize[i], 32'd1);
      end

      // Random traffic with idle gaps.
      gap_pct = 30;
      for (int p = 0; p < 30; p++) push_pkt(16'($urandom), $urandom_range(0, 6));
      wait_idle();
      gap_pct = 0;

      // Reset in the middle of a 10-payload packet.
      push_pkt(16'h0600, 10);
      for (int k = 0; k < 200 && q0.size() > 10; k++) @(negedge clk);
      @(posedge clk);
      #2 rst_ni = 1'b0;
      #1;
      chk("t6_rst_msg_cnt", 0, mcnt[0], 32'd0);
      chk("t6_rst_flit_cnt", 0, fcnt[0], 64'd0);
      chk("t6_rst_credit", 0, credit[0], 1'b0);
      chk("t6_rst_busy", 0, busy[0], 1'b0);
      chk("t6_rst_err", 0, err[0], 1'b0);
      q0.delete();
      q1.delete();
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      push(32'h0000_0701); push(32'd1); push(32'h77);
      wait_idle();
      for (int i = 0; i < 2; i++) begin
         chk("t6_msg_cnt", i, mcnt[i], 32'd1);
         chk("t6_flit_cnt", i, fcnt[i], 64'd3);
         chk("t6_target", i, tgt[i], 16'h0701);
         chk("t6_service", i, lsvc[i], 32'h77);
      end
      chk("t6_latency", 0, llat[0], 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/hermes_port_sink.md
Name: hermes_port_sink

Overview:
- Simulation-side consumer for a Hermes router port left open at the mesh boundary (e.g. an unconnected EAST port of an edge router).
- Terminates the link by returning credit with a configurable back-pressure pattern.
- Parses each packet as header, size, then payload, and exposes per-message results and running counters.
- A passive traffic monitor can tap the same rx/credit/data wires; this block generates the credit that such a monitor qualifies flits with.

Parameters:
- FLIT_SIZE, 32, flit width in bits.
- STALL_PERIOD, 0, credit pattern period in cycles; 0 = credit never deasserted.
- STALL_LEN, 0, cycles per period with credit low; must be < STALL_PERIOD when STALL_PERIOD > 0.
- MAX_SIZE, 32'd4096, largest legal size flit value; larger values flag an error.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- rx_i  in  1  router presents a valid flit.
- data_i  in  FLIT_SIZE  flit data.
- credit_o  out  1  sink can accept a flit this cycle.
- msg_done_o  out  1  one-cycle pulse when a message completes.
- last_target_o  out  16  data_i[15:0] of the completed message's header.
- last_size_o  out  32  size flit of the completed message.
- last_service_o  out  32  first payload flit of the completed message (0 if size = 0).
- last_latency_o  out  32  cycles from header acceptance to last-flit acceptance.
- msg_cnt_o  out  32  completed messages since reset.
- flit_cnt_o  out  64  accepted flits since reset.
- busy_o  out  1  mid-packet (state is not HDR).
- err_o  out  1  sticky: a size > MAX_SIZE was seen.

Behaviour:
- Reset is asynchronous, active-low on rst_ni; clock is clk_i (rising edge).
- During reset all outputs are 0, including credit_o. credit_o rises on the first clock edge after reset release.
- Accept: acc = rx_i && credit_o. Only accepted flits advance the FSM, counters or captures.
- Credit pattern:
  - Free-running stall_cnt counts 0..STALL_PERIOD-1 and wraps.
  - credit_o is registered and low when stall_cnt >= STALL_PERIOD-STALL_LEN, otherwise high.
  - If STALL_PERIOD = 0 or STALL_LEN = 0, credit_o is constantly 1 after reset.
  - The pattern is independent of rx_i.
- FSM states: HDR, SIZE, PAYLOAD.
  - HDR, on acc: capture target = data_i[15:0], clear lat_cnt, go to SIZE.
  - SIZE, on acc: capture size = data_i and remaining = data_i.
    - If data_i == 0: complete the message and go to HDR.
    - Otherwise go to PAYLOAD.
    - If data_i > MAX_SIZE: set err_o (sticky until reset); the packet is still fully consumed.
  - PAYLOAD, on acc: on the first payload flit (remaining == size) capture service = data_i. Decrement remaining. When remaining == 1, complete the message and go to HDR.
- lat_cnt: 0 in the header-acceptance cycle, then increments every cycle while busy_o, including stall cycles. It saturates at 32'hFFFF_FFFF.
- Completion (registered, visible the cycle after the last acceptance):
  - msg_done_o = 1 for exactly one cycle.
  - last_* outputs update together and hold until the next completion.
  - msg_cnt_o increments, wrapping modulo 2^32.
- flit_cnt_o increments on every acc, including header and size flits.
- Back-to-back packets: a header accepted the cycle after a last flit is legal. The next message starts with no bubble.
- Reset mid-packet: the FSM returns to HDR and all counters and captures clear. The partial packet is discarded and not counted.
- data_i is ignored when acc = 0. rx_i held high with credit_o low has no effect.

Test Plan:
- STALL_PERIOD=0; send header 0x0102, size 3, payload 0x10,0xA,0xB with rx_i always high -> credit_o stays 1; 5 flits accepted; msg_done_o pulses once on the cycle after the 5th flit; last_target_o=0x0102, last_size_o=3, last_service_o=0x10, last_latency_o=4, msg_cnt_o=1, flit_cnt_o=5.
- STALL_PERIOD=4, STALL_LEN=2; same packet with continuous rx_i -> credit_o follows 1,1,0,0 repeating; accepted flits occur only in credit-high cycles; last_latency_o=8; payload captured unchanged.
- Size flit 0 -> msg_done_o next cycle, last_size_o=0, last_service_o=0, flit_cnt_o=2, FSM back in HDR (busy_o=0).
- Size 5000 with MAX_SIZE=4096; send all 5000 payload flits -> err_o=1 from the cycle after the size flit and stays 1; msg_cnt_o=1; a following legal packet completes normally with err_o still 1.
- Two 2-payload packets back-to-back with no idle cycles -> two msg_done_o pulses 4 cycles apart; msg_cnt_o=2; flit_cnt_o=8.
- Assert rst_ni low after the size flit of a 10-payload packet -> outputs 0 immediately; after release, a fresh 1-payload packet gives msg_cnt_o=1, flit_cnt_o=3.
